// File: rtl/mips_if_pkg.sv
// Shared types for the MIPS instruction-fetch stage: redirect selectors,
// fetch FSM states and the 32-bit view of a fetch-queue entry.
package mips_if_pkg;

  localparam logic [1:0] REDIR_BR = 2'b00;
  localparam logic [1:0] REDIR_J  = 2'b01;
  localparam logic [1:0] REDIR_JR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  localparam int unsigned IF_XLEN = 32;

  // Entry layout for the 32-bit pipeline; the fetch unit widens pc fields to XLEN.
  typedef struct packed {
    logic [31:0]        instr;
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two circular FIFO with a count register; flush empties it
// in one cycle and takes priority over push and pop.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is reset here (it is tiny) so head reads zero straight out of reset.
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and
// buffers returned instructions for ID; ID redirects flush and squash fetches.
module if_fetch_unit
  import mips_if_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  input  logic            id_ready,
  input  logic            redir_valid,
  input  logic [1:0]      redir_sel,
  input  logic [XLEN-1:0] redir_base,
  input  logic [XLEN-1:0] redir_offset,
  input  logic [25:0]     redir_jaddr,
  input  logic [XLEN-1:0] redir_reg
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } entry_t;

  state_e          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] redir_target;
  logic            drop;
  logic            outstanding;
  logic            accept;
  logic            rsp;
  logic            push;
  logic            pop;
  logic [CNT_W-1:0] q_count;
  logic            q_full;
  logic            q_empty;
  entry_t          push_entry;
  entry_t          head;

  // NOTE: every path assigns redir_target (default arm included), so no latch is inferred.
  always_comb begin
    case (redir_sel)
      REDIR_J:  redir_target = {redir_base[XLEN-1:28], redir_jaddr, 2'b00};
      REDIR_JR: redir_target = redir_reg;
      default:  redir_target = redir_base + redir_offset;
    endcase
  end

  // Gating uses only registered state, keeping id_ready off the imem_req path.
  assign outstanding = (state == WAIT);
  assign imem_req    = (state == REQ) &&
                       (({1'b0, q_count} + {{CNT_W{1'b0}}, outstanding}) < (CNT_W + 1)'(FQ_DEPTH));
  assign imem_addr   = pc;

  assign accept     = imem_req && imem_gnt;
  assign rsp        = outstanding && imem_rvalid;
  assign push       = rsp && !drop && !redir_valid && !q_full;
  assign pop        = !q_empty && id_ready && !redir_valid;
  assign push_entry = '{instr: imem_rdata, pc: req_addr, pc_plus4: req_addr + XLEN'(4)};

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= '0;
      drop     <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (accept) begin
            state    <= WAIT;
            req_addr <= pc;
            pc       <= pc + XLEN'(4);
            drop     <= redir_valid;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state <= REQ;
            drop  <= 1'b0;
          end else if (redir_valid) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Redirect target overrides any sequential pc update from the case above.
      if (redir_valid) pc <= redir_target;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redir_valid),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign if_valid    = !q_empty;
  assign if_instr    = head.instr;
  assign if_pc       = head.pc;
  assign if_pc_plus4 = head.pc_plus4;

endmodule
